// File: rtl/output_controller.sv
// Output port stage: two VC buffers (even/odd), round-robin between link and PE requesters.
// Latency: packet written on one edge is driven on so/dout after the next drain-phase edge.
// Backpressure: ro=0 holds the link-VC packet; its full flag then withholds grants on that VC.
module output_controller #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  req_1,
    input  logic [DATA_WIDTH-1:0] din_1,
    input  logic                  req_2,
    input  logic [DATA_WIDTH-1:0] din_2,
    output logic                  grant_1,
    output logic                  grant_2,
    output logic                  so,
    input  logic                  ro,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  even_full,
    output logic                  odd_full,
    output logic                  vc_err
);

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [1:0]            full_q;
    // rr_q[vc]: 0 -> requester 1 wins a tie on that VC, 1 -> requester 2 wins
    logic [1:0]            rr_q;
    logic                  wr_vc;
    logic                  lk_vc;
    logic [DATA_WIDTH-1:0] din_sel;

    assign wr_vc     = polarity;
    assign lk_vc     = ~polarity;
    assign even_full = full_q[0];
    assign odd_full  = full_q[1];
    assign din_sel   = grant_2 ? din_2 : din_1;

    always_comb begin
        grant_1 = 1'b0;
        grant_2 = 1'b0;
        if (!reset && !full_q[wr_vc]) begin
            if (req_1 && !req_2) begin
                grant_1 = 1'b1;
            end else if (req_2 && !req_1) begin
                grant_2 = 1'b1;
            end else if (req_1 && req_2) begin
                grant_1 = ~rr_q[wr_vc];
                grant_2 = rr_q[wr_vc];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            full_q   <= 2'b00;
            rr_q     <= 2'b00;
            so       <= 1'b0;
            dout     <= '0;
            vc_err   <= 1'b0;
        end else begin
            // Write and link VCs are always different, so both updates can land in one cycle.
            if (grant_1 || grant_2) begin
                buf_q[wr_vc]  <= din_sel;
                full_q[wr_vc] <= 1'b1;
                rr_q[wr_vc]   <= grant_1;
                if (din_sel[VC_BIT] != polarity) begin
                    vc_err <= 1'b1;
                end
            end
            if (full_q[lk_vc] && ro) begin
                so            <= 1'b1;
                dout          <= buf_q[lk_vc];
                full_q[lk_vc] <= 1'b0;
                buf_q[lk_vc]  <= '0;
            end else begin
                so   <= 1'b0;
                dout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_output_controller.sv
// Directed bench for output_controller: grants, buffering, drain, backpressure, vc_err, reset.
module tb_output_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity = 1'b0;
    logic        req_1 = 1'b0;
    logic [63:0] din_1 = '0;
    logic        req_2 = 1'b0;
    logic [63:0] din_2 = '0;
    logic        grant_1;
    logic        grant_2;
    logic        so;
    logic        ro = 1'b0;
    logic [63:0] dout;
    logic        even_full;
    logic        odd_full;
    logic        vc_err;

    int total = 0;
    int bad   = 0;

    output_controller #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .req_1(req_1), .din_1(din_1), .req_2(req_2), .din_2(din_2),
        .grant_1(grant_1), .grant_2(grant_2), .so(so), .ro(ro), .dout(dout),
        .even_full(even_full), .odd_full(odd_full), .vc_err(vc_err)
    );

    always #5 clk = ~clk;

    // Inputs change and registered outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; polarity = 1'b0; req_1 = 1'b1; req_2 = 1'b1; ro = 1'b1;
        step(); step();
        #1;
        total++;
        if ({grant_1, grant_2} !== 2'b00) begin
            bad++; $display("FAIL reset_grants: got %b want 00", {grant_1, grant_2});
        end
        total++;
        if ({so, even_full, odd_full, vc_err} !== 4'b0000 || dout !== 64'h0) begin
            bad++; $display("FAIL reset_state: so/ef/of/err=%b dout=%h want 0000 / 0",
                            {so, even_full, odd_full, vc_err}, dout);
        end
        reset = 1'b0; req_1 = 1'b0; req_2 = 1'b0; ro = 1'b0;
        step();
    endtask

    task automatic test_basic();
        polarity = 1'b0; req_1 = 1'b1; din_1 = 64'h0000_0000_0000_00AA;
        #1;
        total++;
        if ({grant_1, grant_2} !== 2'b10) begin
            bad++; $display("FAIL basic_grant: got %b want 10", {grant_1, grant_2});
        end
        step();
        req_1 = 1'b0;
        total++;
        if ({so, even_full, odd_full} !== 3'b010) begin
            bad++; $display("FAIL basic_stored: so/ef/of=%b want 010", {so, even_full, odd_full});
        end
        polarity = 1'b1; ro = 1'b1;
        step();
        total++;
        if (so !== 1'b1 || dout !== 64'h0000_0000_0000_00AA || even_full !== 1'b0) begin
            bad++; $display("FAIL basic_drain: so=%b dout=%h ef=%b want 1 00000000000000aa 0",
                            so, dout, even_full);
        end
        step();
        total++;
        if (so !== 1'b0 || dout !== 64'h0) begin
            bad++; $display("FAIL basic_idle: so=%b dout=%h want 0 0", so, dout);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g [3];
        logic [63:0] exp_d [3];
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
        exp_d[0] = 64'h8000_0000_0000_0011;
        exp_d[1] = 64'h8000_0000_0000_0022;
        exp_d[2] = 64'h8000_0000_0000_0011;
        din_1 = 64'h8000_0000_0000_0011; din_2 = 64'h8000_0000_0000_0022; ro = 1'b1;
        for (int i = 0; i < 3; i++) begin
            polarity = 1'b1; req_1 = 1'b1; req_2 = 1'b1;
            #1;
            total++;
            if ({grant_1, grant_2} !== exp_g[i]) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {grant_1, grant_2}, exp_g[i]);
            end
            step();
            polarity = 1'b0; req_1 = 1'b0; req_2 = 1'b0;
            step();
            total++;
            if (so !== 1'b1 || dout !== exp_d[i] || odd_full !== 1'b0) begin
                bad++; $display("FAIL rr_drain[%0d]: so=%b dout=%h of=%b want 1 %h 0",
                                i, so, dout, odd_full, exp_d[i]);
            end
        end
        total++;
        if (vc_err !== 1'b0) begin
            bad++; $display("FAIL rr_vc_err: got %b want 0", vc_err);
        end
    endtask

    task automatic test_backpressure();
        polarity = 1'b1; req_2 = 1'b1; din_2 = 64'h8000_0000_0000_0033; ro = 1'b0;
        step();
        din_2 = 64'h8000_0000_0000_0044;
        for (int i = 0; i < 6; i++) begin
            polarity = (i % 2 == 0) ? 1'b0 : 1'b1;
            req_2 = polarity;
            #1;
            total++;
            if (grant_2 !== 1'b0 || so !== 1'b0 || odd_full !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d]: g2=%b so=%b of=%b want 0 0 1",
                                i, grant_2, so, odd_full);
            end
            step();
        end
        polarity = 1'b0; req_2 = 1'b0; ro = 1'b1;
        step();
        total++;
        if (so !== 1'b1 || dout !== 64'h8000_0000_0000_0033 || odd_full !== 1'b0) begin
            bad++; $display("FAIL bp_release: so=%b dout=%h of=%b want 1 8000000000000033 0",
                            so, dout, odd_full);
        end
        polarity = 1'b1; req_2 = 1'b1;
        #1;
        total++;
        if (grant_2 !== 1'b1) begin
            bad++; $display("FAIL bp_regrant: g2=%b want 1", grant_2);
        end
        step();
        polarity = 1'b0; req_2 = 1'b0;
        step();
        total++;
        if (so !== 1'b1 || dout !== 64'h8000_0000_0000_0044) begin
            bad++; $display("FAIL bp_second: so=%b dout=%h want 1 8000000000000044", so, dout);
        end
    endtask

    task automatic test_vc_err();
        polarity = 1'b0; req_2 = 1'b1; din_2 = 64'h8000_0000_0000_0055;
        #1;
        total++;
        if (grant_2 !== 1'b1 || vc_err !== 1'b0) begin
            bad++; $display("FAIL vc_grant: g2=%b err=%b want 1 0", grant_2, vc_err);
        end
        step();
        req_2 = 1'b0;
        total++;
        if (even_full !== 1'b1 || vc_err !== 1'b1) begin
            bad++; $display("FAIL vc_set: ef=%b err=%b want 1 1", even_full, vc_err);
        end
        polarity = 1'b1; ro = 1'b1;
        step();
        total++;
        if (so !== 1'b1 || dout !== 64'h8000_0000_0000_0055) begin
            bad++; $display("FAIL vc_stored: so=%b dout=%h want 1 8000000000000055", so, dout);
        end
        step(); step();
        total++;
        if (vc_err !== 1'b1) begin
            bad++; $display("FAIL vc_sticky: err=%b want 1", vc_err);
        end
    endtask

    task automatic test_reset_mid();
        ro = 1'b0; polarity = 1'b0; req_1 = 1'b1; din_1 = 64'h0000_0000_0000_0066;
        step();
        polarity = 1'b1; din_1 = 64'h8000_0000_0000_0077;
        step();
        req_1 = 1'b0;
        total++;
        if ({even_full, odd_full} !== 2'b11) begin
            bad++; $display("FAIL mid_fill: ef/of=%b want 11", {even_full, odd_full});
        end
        reset = 1'b1; polarity = 1'b0; ro = 1'b1;
        step();
        total++;
        if ({so, even_full, odd_full, vc_err} !== 4'b0000 || dout !== 64'h0) begin
            bad++; $display("FAIL mid_reset: so/ef/of/err=%b dout=%h want 0000 / 0",
                            {so, even_full, odd_full, vc_err}, dout);
        end
        reset = 1'b0;
        step();
        total++;
        if (so !== 1'b0 || dout !== 64'h0) begin
            bad++; $display("FAIL mid_no_drain: so=%b dout=%h want 0 0", so, dout);
        end
        // Even-VC pointer favoured requester 2 before reset; reset returns it to requester 1.
        req_1 = 1'b1; req_2 = 1'b1;
        #1;
        total++;
        if ({grant_1, grant_2} !== 2'b10) begin
            bad++; $display("FAIL mid_rr_reset: got %b want 10", {grant_1, grant_2});
        end
        req_1 = 1'b0; req_2 = 1'b0;
        step();
    endtask

    task automatic test_same_cycle();
        ro = 1'b0; polarity = 1'b1; req_1 = 1'b1; din_1 = 64'h8000_0000_0000_0088;
        step();
        polarity = 1'b0; din_1 = 64'h0000_0000_0000_0099; ro = 1'b1;
        #1;
        total++;
        if ({grant_1, grant_2} !== 2'b10) begin
            bad++; $display("FAIL same_grant: got %b want 10", {grant_1, grant_2});
        end
        step();
        req_1 = 1'b0;
        total++;
        if ({so, even_full, odd_full} !== 3'b110 || dout !== 64'h8000_0000_0000_0088) begin
            bad++; $display("FAIL same_both: so/ef/of=%b dout=%h want 110 8000000000000088",
                            {so, even_full, odd_full}, dout);
        end
        polarity = 1'b1;
        step();
        total++;
        if (so !== 1'b1 || dout !== 64'h0000_0000_0000_0099 || vc_err !== 1'b0) begin
            bad++; $display("FAIL same_even_drain: so=%b dout=%h err=%b want 1 0000000000000099 0",
                            so, dout, vc_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_vc_err();
        test_reset_mid();
        test_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
